// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single instruction register (IR)
// and a valid/ready handshake toward the decode stage.
// Widths come from the PC_SIZE / INSTR_SIZE macros (defaults below).
// Optional feature macro: FETCH_HALT_EN -- when defined, an instruction with
// opcode 6'h3F is delivered normally and then fetch halts until reset.

`ifndef PC_SIZE
`define PC_SIZE 8
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module fetch_unit (
  input  logic                   clock,
  input  logic                   nReset,
  output logic [`PC_SIZE-1:0]    imem_addr,
  input  logic [`INSTR_SIZE-1:0] imem_instr,
  input  logic                   stall,
  input  logic                   jump,
  input  logic [25:0]            jump_addr,
  input  logic                   branch_taken,
  input  logic [15:0]            branch_offset,
  output logic [`INSTR_SIZE-1:0] instr,
  output logic [`PC_SIZE-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   halted
);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HALT} state_t;

  state_t                 state, state_next;
  logic [`PC_SIZE-1:0]    pc, pc_next;
  logic [`PC_SIZE-1:0]    instr_pc_next;
  logic [`INSTR_SIZE-1:0] instr_next;
  logic                   instr_valid_next;
  logic [`PC_SIZE-1:0]    seq_pc, branch_target, jump_target;
  logic [`PC_SIZE+15:0]   offset_wide;
  logic                   redirect, capture, halt_op;

  // The ROM is addressed straight from the PC so the read data is ready
  // to be captured on the same edge that advances the PC.
  assign imem_addr = pc;

  // Both redirect targets are relative to the instruction held in the IR.
  assign seq_pc        = instr_pc + `PC_SIZE'(1);
  assign offset_wide   = {{`PC_SIZE{branch_offset[15]}}, branch_offset};
  assign branch_target = seq_pc + offset_wide[`PC_SIZE-1:0];
  wire   unused_offset_bits = ^offset_wide[`PC_SIZE+15:`PC_SIZE];

  // A narrow PC takes the low jump field bits; a wide PC keeps its upper
  // bits from the sequential address, as in a MIPS-style J-type jump.
  if (`PC_SIZE <= 26) begin : g_jump_narrow
    assign jump_target = jump_addr[`PC_SIZE-1:0];
    if (`PC_SIZE < 26) begin : g_jump_spare
      wire unused_jump_bits = ^jump_addr[25:`PC_SIZE];
    end
  end else begin : g_jump_wide
    assign jump_target = {seq_pc[`PC_SIZE-1:26], jump_addr};
  end

`ifdef FETCH_HALT_EN
  assign halt_op = (imem_instr[31:26] == 6'h3F);
  assign halted  = (state == HALT);
`else
  assign halt_op = 1'b0;
  assign halted  = 1'b0;
`endif

  // A redirect needs a held instruction to be relative to; a new
  // instruction is captured only when the IR is empty or being drained.
  assign redirect = (jump || branch_taken) && instr_valid && (state != HALT);
  assign capture  = (state == FETCH) && !stall && (!instr_valid || instr_ready);

  // Next-state logic: redirect wins over everything, otherwise the state
  // decides whether a new instruction is captured this cycle.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    instr_next       = instr;
    instr_pc_next    = instr_pc;
    instr_valid_next = instr_valid;
    if (instr_valid && instr_ready) begin
      instr_valid_next = 1'b0;
    end
    if (redirect) begin
      pc_next          = jump ? jump_target : branch_target;
      instr_valid_next = 1'b0;
      state_next       = FLUSH;
    end else begin
      case (state)
        IDLE:  state_next = FETCH;
        FETCH: begin
          if (capture) begin
            instr_next       = imem_instr;
            instr_pc_next    = pc;
            instr_valid_next = 1'b1;
            pc_next          = pc + `PC_SIZE'(1);
            if (halt_op) begin
              state_next = HALT;
            end
          end
        end
        FLUSH:   state_next = FETCH;
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // State, PC and IR registers; reset restarts fetch from address 0.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= instr_valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked against
// a transaction-level model of the fetch stage.

`ifndef PC_SIZE
`define PC_SIZE 8
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module tb_fetch_unit;

  localparam int PCW   = `PC_SIZE;
  localparam int DEPTH = 1 << PCW;

  logic                   clock = 1'b0;
  logic                   nReset = 1'b0;
  logic [`PC_SIZE-1:0]    imem_addr;
  logic [`INSTR_SIZE-1:0] imem_instr;
  logic                   stall = 1'b0;
  logic                   jump = 1'b0;
  logic [25:0]            jump_addr = '0;
  logic                   branch_taken = 1'b0;
  logic [15:0]            branch_offset = '0;
  logic [`INSTR_SIZE-1:0] instr;
  logic [`PC_SIZE-1:0]    instr_pc;
  logic                   instr_valid;
  logic                   instr_ready = 1'b0;
  logic                   halted;

  logic [31:0] rom [DEPTH];
  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clock(clock), .nReset(nReset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .jump(jump), .jump_addr(jump_addr), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted)
  );

  assign imem_instr = rom[imem_addr];

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'h11 * (i + 1);
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_addr = '0; branch_offset = '0; instr_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    nReset = 1'b1;
  endtask

  task automatic test_reset();
    fill_pattern();
    do_reset();
    repeat (4) tick();
    jump = 1'b1; jump_addr = 26'd40;
    #2;
    nReset = 1'b0;
    #1;
    checks++; if (imem_addr !== '0) begin errors++; $display("[TB] FAIL rst_addr: got %0d, expected 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %0b, expected 0", instr_valid); end
    checks++; if (instr !== '0) begin errors++; $display("[TB] FAIL rst_instr: got %h, expected 0", instr); end
    checks++; if (instr_pc !== '0) begin errors++; $display("[TB] FAIL rst_instr_pc: got %0d, expected 0", instr_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL rst_halted: got %0b, expected 0", halted); end
    jump = 1'b0;
    @(posedge clock);
    #1;
    nReset = 1'b1;
    tick();
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== '0) begin errors++; $display("[TB] FAIL rst_restart: got valid=%0b pc=%0d, expected valid=1 pc=0", instr_valid, instr_pc); end
  endtask

  task automatic test_sequential();
    fill_pattern();
    do_reset();
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_idle_valid: got %0b, expected 0", instr_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== PCW'(i) || instr !== 32'h11 * (i + 1)) begin
        errors++; $display("[TB] FAIL seq_word%0d: got valid=%0b pc=%0d instr=%h, expected valid=1 pc=%0d instr=%h", i, instr_valid, instr_pc, instr, i, 32'h11 * (i + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    fill_pattern();
    do_reset();
    repeat (3) tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== PCW'(1) || instr !== rom[1] || imem_addr !== PCW'(2)) begin
        errors++; $display("[TB] FAIL hold_cycle%0d: got valid=%0b pc=%0d instr=%h addr=%0d, expected valid=1 pc=1 instr=%h addr=2", i, instr_valid, instr_pc, instr, imem_addr, rom[1]);
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== PCW'(2)) begin errors++; $display("[TB] FAIL hold_release: got valid=%0b pc=%0d, expected valid=1 pc=2", instr_valid, instr_pc); end
  endtask

  task automatic test_redirect();
    fill_pattern();
    do_reset();
    repeat (6) tick();
    checks++; if (instr_pc !== PCW'(4)) begin errors++; $display("[TB] FAIL br_setup: got pc=%0d, expected 4", instr_pc); end
    branch_taken = 1'b1; branch_offset = 16'hFFFD;
    tick();
    checks++; if (instr_valid !== 1'b0 || imem_addr !== PCW'(2)) begin errors++; $display("[TB] FAIL br_bubble1: got valid=%0b addr=%0d, expected valid=0 addr=2", instr_valid, imem_addr); end
    branch_taken = 1'b0; jump = 1'b1; jump_addr = 26'd20;
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL br_bubble2: got valid=%0b, expected 0", instr_valid); end
    jump = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== PCW'(2) || instr !== rom[2]) begin errors++; $display("[TB] FAIL br_target: got valid=%0b pc=%0d, expected valid=1 pc=2", instr_valid, instr_pc); end
    tick();
    tick();
    jump = 1'b1; jump_addr = 26'd9; branch_taken = 1'b1; branch_offset = 16'hFFFD;
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL jmp_bubble1: got valid=%0b, expected 0", instr_valid); end
    jump = 1'b0; branch_taken = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL jmp_bubble2: got valid=%0b, expected 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== PCW'(9) || instr !== rom[9]) begin errors++; $display("[TB] FAIL jmp_target: got valid=%0b pc=%0d, expected valid=1 pc=9", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap_stall();
    fill_pattern();
    do_reset();
    repeat (2) tick();
    jump = 1'b1; jump_addr = 26'(DEPTH - 2);
    tick();
    jump = 1'b0;
    repeat (2) tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== PCW'(DEPTH - 2)) begin errors++; $display("[TB] FAIL wrap_m2: got valid=%0b pc=%0d, expected valid=1 pc=%0d", instr_valid, instr_pc, DEPTH - 2); end
    tick();
    checks++; if (instr_pc !== PCW'(DEPTH - 1) || imem_addr !== '0) begin errors++; $display("[TB] FAIL wrap_max: got pc=%0d addr=%0d, expected pc=%0d addr=0", instr_pc, imem_addr, DEPTH - 1); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== '0) begin errors++; $display("[TB] FAIL wrap_zero: got valid=%0b pc=%0d, expected valid=1 pc=0", instr_valid, instr_pc); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b0 || imem_addr !== PCW'(1)) begin errors++; $display("[TB] FAIL stall_cycle%0d: got valid=%0b addr=%0d, expected valid=0 addr=1", i, instr_valid, imem_addr); end
    end
    stall = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== PCW'(1)) begin errors++; $display("[TB] FAIL stall_resume: got valid=%0b pc=%0d, expected valid=1 pc=1", instr_valid, instr_pc); end
  endtask

  task automatic test_halt();
    fill_pattern();
    rom[2] = 32'hFC00_0000;
    do_reset();
    repeat (4) tick();
`ifdef FETCH_HALT_EN
    checks++; if (instr_pc !== PCW'(2) || instr !== 32'hFC00_0000 || halted !== 1'b1 || imem_addr !== PCW'(3)) begin
      errors++; $display("[TB] FAIL halt_capture: got pc=%0d instr=%h halted=%0b addr=%0d, expected pc=2 instr=fc000000 halted=1 addr=3", instr_pc, instr, halted, imem_addr);
    end
    jump = 1'b1; jump_addr = 26'd9; instr_ready = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== PCW'(2) || imem_addr !== PCW'(3)) begin errors++; $display("[TB] FAIL halt_ignore_jump: got valid=%0b pc=%0d addr=%0d, expected valid=1 pc=2 addr=3", instr_valid, instr_pc, imem_addr); end
    jump = 1'b0; instr_ready = 1'b1;
    repeat (4) tick();
    checks++; if (instr_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== PCW'(3)) begin errors++; $display("[TB] FAIL halt_frozen: got valid=%0b halted=%0b addr=%0d, expected valid=0 halted=1 addr=3", instr_valid, halted, imem_addr); end
`else
    checks++; if (instr_pc !== PCW'(2) || halted !== 1'b0 || imem_addr !== PCW'(3)) begin errors++; $display("[TB] FAIL nohalt_capture: got pc=%0d halted=%0b addr=%0d, expected pc=2 halted=0 addr=3", instr_pc, halted, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== PCW'(3) || halted !== 1'b0) begin errors++; $display("[TB] FAIL nohalt_continue: got valid=%0b pc=%0d halted=%0b, expected valid=1 pc=3 halted=0", instr_valid, instr_pc, halted); end
`endif
    do_reset();
    checks++; if (halted !== 1'b0 || imem_addr !== '0) begin errors++; $display("[TB] FAIL halt_reset: got halted=%0b addr=%0d, expected halted=0 addr=0", halted, imem_addr); end
    rom[2] = 32'h33;
  endtask

  task automatic test_random();
    longint mask, m_pc, m_ipc;
    logic [31:0] m_instr;
    bit m_valid, m_halted, redir;
    int block;
    mask = longint'(DEPTH) - 1;
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom & 32'h7FFF_FFFF;
    do_reset();
    m_pc = 0; m_ipc = 0; m_instr = '0; m_valid = 1'b0; m_halted = 1'b0; block = 1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      instr_ready   = ($urandom_range(0, 9) < 7);
      stall         = ($urandom_range(0, 9) < 2);
      jump          = ($urandom_range(0, 19) == 0);
      branch_taken  = ($urandom_range(0, 14) == 0);
      jump_addr     = 26'($urandom);
      branch_offset = 16'($urandom);
      @(posedge clock);
      redir = (jump || branch_taken) && m_valid && !m_halted;
      if (redir) begin
        if (jump) begin
          if (PCW <= 26) m_pc = longint'(jump_addr) & mask;
          else m_pc = ((((m_ipc + 1) & mask) >> 26) << 26) | longint'(jump_addr);
        end else begin
          m_pc = (m_ipc + 1 + longint'($signed(branch_offset))) & mask;
        end
        m_valid = 1'b0;
        block = 1;
      end else if (block > 0) begin
        block--;
        if (m_valid && instr_ready) m_valid = 1'b0;
      end else if (!m_halted && !stall && (!m_valid || instr_ready)) begin
        m_instr = rom[m_pc];
        m_ipc = m_pc;
        m_valid = 1'b1;
        m_pc = (m_pc + 1) & mask;
`ifdef FETCH_HALT_EN
        if (m_instr[31:26] == 6'h3F) m_halted = 1'b1;
`endif
      end else if (m_valid && instr_ready) begin
        m_valid = 1'b0;
      end
      #1;
      checks++; if (imem_addr !== PCW'(m_pc)) begin errors++; $display("[TB] FAIL rnd_addr cyc%0d: got %0d, expected %0d", cyc, imem_addr, m_pc); end
      checks++; if (instr_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid cyc%0d: got %0b, expected %0b", cyc, instr_valid, m_valid); end
      if (m_valid) begin
        checks++; if (instr_pc !== PCW'(m_ipc) || instr !== m_instr) begin
          errors++; $display("[TB] FAIL rnd_instr cyc%0d: got pc=%0d instr=%h, expected pc=%0d instr=%h", cyc, instr_pc, instr, m_ipc, m_instr);
        end
      end
    end
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
  endtask

  // Run every scenario in turn, then report the totals.
  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_wrap_stall();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Widths SHALL come from `PC_SIZE (word address) and `INSTR_SIZE (32) in config.sv; no parameters.
REQ-002 clock  input  1  single clock; all state on rising edge.
REQ-003 nReset  input  1  asynchronous, active-low reset.
REQ-004 imem_addr  output  `PC_SIZE  word address to instruction ROM; equals PC combinationally.
REQ-005 imem_instr  input  `INSTR_SIZE  ROM read data, combinational from imem_addr.
REQ-006 stall  input  1  freeze fetch.
REQ-007 jump  input  1  redirect to J-type target of held instruction.
REQ-008 jump_addr  input  26  J-type address field.
REQ-009 branch_taken  input  1  redirect to PC-relative target of held instruction.
REQ-010 branch_offset  input  16  signed word offset (I-type immediate).
REQ-011 instr  output  `INSTR_SIZE  held instruction (IR).
REQ-012 instr_pc  output  `PC_SIZE  word address of instr.
REQ-013 instr_valid  output  1  IR holds an undelivered instruction.
REQ-014 instr_ready  input  1  consumer accepts instr this cycle.
REQ-015 halted  output  1  fetch halted (see Configuration).

Function
REQ-016 States SHALL be IDLE, FETCH, FLUSH, HALT; encoding free.
REQ-017 IDLE SHALL go to FETCH on the first clock after reset release, no capture.
REQ-018 Capture condition cap = (state==FETCH) && !stall && (!instr_valid || instr_ready).
REQ-019 On cap: instr<=imem_instr, instr_pc<=PC, instr_valid<=1, PC<=PC+1; one instruction per cycle under continuous ready.
REQ-020 If instr_valid && instr_ready and no cap, instr_valid SHALL clear next edge.
REQ-021 If !instr_ready, instr, instr_pc, instr_valid SHALL hold unchanged.
REQ-022 stall SHALL block capture and PC update only; a pending handshake (REQ-020) still completes.
REQ-023 PC+1 SHALL wrap modulo 2^`PC_SIZE (max -> 0).
REQ-024 Redirect (jump||branch_taken) SHALL be honoured only when instr_valid and state!=HALT; otherwise ignored.
REQ-025 Branch target = instr_pc + 1 + sign_extend(branch_offset), modulo 2^`PC_SIZE.
REQ-026 Jump target = jump_addr[`PC_SIZE-1:0] if `PC_SIZE<=26, else {upper bits of instr_pc+1, jump_addr}.
REQ-027 jump SHALL take priority over branch_taken when both asserted.
REQ-028 Honoured redirect SHALL override stall and cap: PC<=target, instr_valid<=0, state<=FLUSH.
REQ-029 FLUSH SHALL last one cycle, no capture, then FETCH; a redirect yields exactly 2 cycles with instr_valid low before the target instruction is valid.

Reset
REQ-030 nReset low SHALL immediately force PC=0, instr=0, instr_pc=0, instr_valid=0, halted=0, state=IDLE.
REQ-031 Reset mid-operation SHALL discard IR contents and pending redirect; fetch restarts at address 0.

Configuration
REQ-032 Macro FETCH_HALT_EN defined: a captured instruction with opcode[31:26]==6'h3F SHALL be delivered normally, then state<=HALT, halted<=1, PC frozen, no further capture until reset; redirects ignored in HALT.
REQ-033 FETCH_HALT_EN undefined: opcode 6'h3F SHALL be an ordinary instruction, HALT unreachable, halted tied 0.

Verification
REQ-034 ROM words 0..3 = 0x11,0x22,0x33,0x44, ready=1, release reset -> instr_valid first high 2 edges after release with instr_pc=0, instr=0x11; then 1,2,3 on consecutive cycles.
REQ-035 ready=0 for 3 cycles while holding instr_pc=1 -> instr, instr_pc, instr_valid, imem_addr all stable; ready=1 -> instr_pc=2 next cycle.
REQ-036 instr_pc=4 held, branch_taken=1, offset=0xFFFD -> instr_valid low 2 cycles, next delivered instr_pc=2; repeat with jump=1, jump_addr=9 also asserted -> instr_pc=9.
REQ-037 PC at 2^`PC_SIZE-1 with ready=1 -> instr_pc sequence max, 0; stall=1 for 2 cycles -> no new captures, held instruction still handshakes once.
REQ-038 With FETCH_HALT_EN, ROM word 2 = 0xFC000000 -> instr_pc 0,1,2 delivered, halted=1 after capture of 2, imem_addr stays 3; without macro -> fetch continues to 3, halted=0.
